div_seq_ctrl: RTL and testbench

- Sequencing controller between the EX stage and the iterative 32-bit divider core (start/annul/ready handshake).
- Decodes DIV/DIVU from the ALU control code and latches the operands for the whole operation.
- Generates the pipeline stall, short-circuits divide-by-zero, honours flush (annul) and downstream holds.
- Issues a single HI/LO write per completed division.

---
 rtl/div_seq_ctrl.sv | 156 +++++++++++++++
 tb/tb_div_seq_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl
//   Sequencing controller between the EX stage and the iterative 32-bit
//   divider core. Decodes DIV/DIVU, latches the operands for the whole
//   operation, stalls the pipeline while the core works, short-circuits
//   divide-by-zero, honours flush (annul) and downstream holds, and issues
//   exactly one HI/LO write per completed division.
//
// Ports
//   clk, rst           clock (rising edge), synchronous active-high reset
//   alu_control_i      EX-stage ALU control code
//   opdata1_i/2_i      dividend / divisor from EX
//   flush_i            annul of the EX instruction
//   stall_ext_i        hold from a later pipeline stage
//   div_ready_i        core completion pulse
//   div_result_i       core result {remainder, quotient}
//   div_start_o        core start, high for the whole operation
//   div_annul_o        core abort pulse
//   div_signed_o       latched signedness
//   div_op1_o/op2_o    latched operands
//   stall_o            pipeline stall request (combinational)
//   hilo_we_o          HI/LO write enable, one cycle per division
//   hi_o / lo_o        remainder / quotient
//   busy_err_o         one-cycle pulse on watchdog abort
module div_seq_ctrl #(
  parameter int          MAX_CYCLES = 40,
  parameter int          CNT_W      = 6,
  parameter logic [7:0]  ALU_DIV    = 8'h1A,
  parameter logic [7:0]  ALU_DIVU   = 8'h1B
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  alu_control_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        flush_i,
  input  logic        stall_ext_i,
  input  logic        div_ready_i,
  input  logic [63:0] div_result_i,
  output logic        div_start_o,
  output logic        div_annul_o,
  output logic        div_signed_o,
  output logic [31:0] div_op1_o,
  output logic [31:0] div_op2_o,
  output logic        stall_o,
  output logic        hilo_we_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        busy_err_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;

  logic w_div_op;
  logic w_accept;
  logic w_div0;
  logic w_capture;
  logic w_annul;
  logic w_wd_err;
  logic w_we;

  assign w_div_op = (alu_control_i == ALU_DIV) | (alu_control_i == ALU_DIVU);
  assign w_div0   = (opdata2_i == 32'd0);

  // After a watchdog abort the stalled DIV is still sitting in EX during the
  // busy_err_o cycle; refusing it there keeps it from re-triggering and lets
  // the pipeline move it on.
  assign w_accept = (r_state == IDLE) & w_div_op & !flush_i & !busy_err_o;

  assign stall_o = !rst & !flush_i & (w_accept | (r_state == BUSY));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Priority inside BUSY: flush > watchdog > ready.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_annul     = 1'b0;
    w_wd_err    = 1'b0;
    w_we        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_nxt = w_div0 ? DONE : BUSY;
      end
      BUSY: begin
        if (flush_i) begin
          w_annul     = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_cnt == CNT_W'(MAX_CYCLES - 1)) begin
          w_annul     = 1'b1;
          w_wd_err    = 1'b1;
          w_state_nxt = IDLE;
        end else if (div_ready_i) begin
          w_capture   = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (flush_i) begin
          w_state_nxt = IDLE;
        end else if (!stall_ext_i) begin
          w_we        = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      div_start_o  <= 1'b0;
      div_annul_o  <= 1'b0;
      div_signed_o <= 1'b0;
      div_op1_o    <= '0;
      div_op2_o    <= '0;
      hilo_we_o    <= 1'b0;
      hi_o         <= '0;
      lo_o         <= '0;
      busy_err_o   <= 1'b0;
    end else begin
      div_annul_o <= w_annul;
      busy_err_o  <= w_wd_err;
      hilo_we_o   <= w_we;

      if (w_accept)              r_cnt <= '0;
      else if (r_state == BUSY)  r_cnt <= r_cnt + CNT_W'(1);

      if (w_accept) begin
        div_op1_o    <= opdata1_i;
        div_op2_o    <= opdata2_i;
        div_signed_o <= (alu_control_i == ALU_DIV);
        div_start_o  <= !w_div0;
        if (w_div0) begin
          hi_o <= opdata1_i;
          lo_o <= 32'hFFFF_FFFF;
        end
      end else if (r_state == BUSY && w_state_nxt != BUSY) begin
        div_start_o <= 1'b0;
      end

      if (w_capture) begin
        hi_o <= div_result_i[63:32];
        lo_o <= div_result_i[31:0];
      end
    end
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl. The divider core is played by the bench
// driving div_ready_i / div_result_i with hand-computed results.
module tb_div_seq_ctrl;

  localparam logic [7:0] DIV  = 8'h1A;
  localparam logic [7:0] DIVU = 8'h1B;
  localparam logic [7:0] NOP  = 8'h00;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  alu_control_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic        flush_i, stall_ext_i, div_ready_i;
  logic [63:0] div_result_i;
  logic        div_start_o, div_annul_o, div_signed_o;
  logic [31:0] div_op1_o, div_op2_o;
  logic        stall_o, hilo_we_o, busy_err_o;
  logic [31:0] hi_o, lo_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_seq_ctrl dut (
    .clk(clk), .rst(rst), .alu_control_i(alu_control_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .flush_i(flush_i),
    .stall_ext_i(stall_ext_i), .div_ready_i(div_ready_i),
    .div_result_i(div_result_i), .div_start_o(div_start_o),
    .div_annul_o(div_annul_o), .div_signed_o(div_signed_o),
    .div_op1_o(div_op1_o), .div_op2_o(div_op2_o), .stall_o(stall_o),
    .hilo_we_o(hilo_we_o), .hi_o(hi_o), .lo_o(lo_o),
    .busy_err_o(busy_err_o)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      $error("check %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full non-zero-divisor division: accept, nb BUSY cycles (ready in the
  // last one), one DONE cycle, then the write pulse.
  task automatic do_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int nb, input logic [63:0] res);
    alu_control_i = op; opdata1_i = a; opdata2_i = b;
    #1 chk("acc_stall", 64'(stall_o), 1);
    chk("acc_no_start", 64'(div_start_o), 0);
    tick();
    for (int i = 0; i < nb - 1; i++) begin
      chk("busy_start", 64'(div_start_o), 1);
      chk("busy_stall", 64'(stall_o), 1);
      tick();
    end
    div_ready_i = 1'b1; div_result_i = res;
    #1 chk("rdy_stall", 64'(stall_o), 1);
    chk("rdy_op1", 64'(div_op1_o), 64'(a));
    tick();
    div_ready_i = 1'b0; div_result_i = 64'hDEAD_BEEF_0BAD_F00D;
    alu_control_i = NOP;
    #1 chk("done_start", 64'(div_start_o), 0);
    chk("done_we", 64'(hilo_we_o), 0);
    chk("done_stall", 64'(stall_o), 0);
    tick();
    chk("we_pulse", 64'(hilo_we_o), 1);
    tick();
    chk("we_single", 64'(hilo_we_o), 0);
  endtask

  initial begin
    rst = 1'b1; alu_control_i = DIV; opdata1_i = 32'd5; opdata2_i = 32'd1;
    flush_i = 1'b0; stall_ext_i = 1'b0; div_ready_i = 1'b0; div_result_i = '0;

    // Reset state, with a DIV present on the inputs
    tick(); tick();
    #1 chk("rst_stall", 64'(stall_o), 0);
    chk("rst_start", 64'(div_start_o), 0);
    chk("rst_we", 64'(hilo_we_o), 0);
    chk("rst_hilo", {hi_o, lo_o}, 64'd0);
    chk("rst_ops", {div_op1_o, div_op2_o}, 64'd0);
    chk("rst_err", 64'({busy_err_o, div_annul_o, div_signed_o}), 0);
    alu_control_i = NOP;
    rst = 1'b0;
    tick();

    // 1. Signed DIV 100 / 7
    do_div(DIV, 32'd100, 32'd7, 5, {32'd2, 32'd14});
    chk("t1_lo", 64'(lo_o), 14);
    chk("t1_hi", 64'(hi_o), 2);
    chk("t1_signed", 64'(div_signed_o), 1);

    // 2. Signed negative and unsigned
    do_div(DIV, 32'hFFFF_FFF9, 32'd2, 3, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    chk("t2a_lo", 64'(lo_o), 64'h0000_0000_FFFF_FFFD);
    chk("t2a_hi", 64'(hi_o), 64'h0000_0000_FFFF_FFFF);
    do_div(DIVU, 32'hFFFF_FFFF, 32'd2, 1, {32'd1, 32'h7FFF_FFFF});
    chk("t2b_lo", 64'(lo_o), 64'h7FFF_FFFF);
    chk("t2b_hi", 64'(hi_o), 1);
    chk("t2b_signed", 64'(div_signed_o), 0);

    // 3. Divide-by-zero
    alu_control_i = DIVU; opdata1_i = 32'h1234_5678; opdata2_i = 32'd0;
    #1 chk("dz_acc_stall", 64'(stall_o), 1);
    tick();
    alu_control_i = NOP;
    #1 chk("dz_stall", 64'(stall_o), 0);
    chk("dz_start", 64'(div_start_o), 0);
    chk("dz_lo", 64'(lo_o), 64'hFFFF_FFFF);
    chk("dz_hi", 64'(hi_o), 64'h1234_5678);
    chk("dz_we0", 64'(hilo_we_o), 0);
    tick();
    chk("dz_we", 64'(hilo_we_o), 1);
    chk("dz_start2", 64'(div_start_o), 0);
    tick();
    chk("dz_we_single", 64'(hilo_we_o), 0);

    // 4a. Flush at BUSY cycle 10
    alu_control_i = DIV; opdata1_i = 32'd50; opdata2_i = 32'd5;
    tick();
    for (int i = 1; i < 10; i++) tick();
    chk("fl_start_pre", 64'(div_start_o), 1);
    flush_i = 1'b1;
    #1 chk("fl_stall", 64'(stall_o), 0);
    tick();
    flush_i = 1'b0; alu_control_i = NOP;
    #1 chk("fl_annul", 64'(div_annul_o), 1);
    chk("fl_start", 64'(div_start_o), 0);
    chk("fl_stall2", 64'(stall_o), 0);
    chk("fl_we", 64'(hilo_we_o), 0);
    tick();
    chk("fl_annul_pulse", 64'(div_annul_o), 0);
    chk("fl_we2", 64'(hilo_we_o), 0);

    // 4b. Flush coincident with ready: no capture, no write
    alu_control_i = DIV; opdata1_i = 32'd60; opdata2_i = 32'd6;
    tick();
    flush_i = 1'b1; div_ready_i = 1'b1; div_result_i = {32'd0, 32'd10};
    tick();
    flush_i = 1'b0; div_ready_i = 1'b0; alu_control_i = NOP;
    chk("flr_annul", 64'(div_annul_o), 1);
    chk("flr_lo", 64'(lo_o), 64'hFFFF_FFFF);
    tick();
    chk("flr_we", 64'(hilo_we_o), 0);
    tick();
    chk("flr_we2", 64'(hilo_we_o), 0);

    // Stray ready in IDLE is ignored
    div_ready_i = 1'b1; div_result_i = {32'd7, 32'd7};
    tick();
    div_ready_i = 1'b0;
    tick();
    chk("stray_lo", 64'(lo_o), 64'hFFFF_FFFF);
    chk("stray_we", 64'(hilo_we_o), 0);

    // 5. External hold in DONE, operands changed mid-BUSY
    alu_control_i = DIVU; opdata1_i = 32'd1000; opdata2_i = 32'd3;
    tick();
    opdata1_i = 32'd5; opdata2_i = 32'd9;
    tick();
    chk("hold_op1", 64'(div_op1_o), 1000);
    chk("hold_op2", 64'(div_op2_o), 3);
    div_ready_i = 1'b1; div_result_i = {32'd1, 32'd333};
    tick();
    div_ready_i = 1'b0; div_result_i = '0; stall_ext_i = 1'b1; alu_control_i = NOP;
    #1 chk("hold_stall", 64'(stall_o), 0);
    for (int i = 0; i < 3; i++) begin
      chk("hold_we", 64'(hilo_we_o), 0);
      chk("hold_res", {hi_o, lo_o}, {32'd1, 32'd333});
      if (i == 2) stall_ext_i = 1'b0;
      tick();
    end
    chk("hold_we_rel", 64'(hilo_we_o), 1);
    tick();
    chk("hold_we_single", 64'(hilo_we_o), 0);

    // 6a. Watchdog: ready never arrives
    alu_control_i = DIV; opdata1_i = 32'd7; opdata2_i = 32'd1;
    tick();
    for (int i = 1; i < 40; i++) begin
      chk("wd_start", 64'(div_start_o), 1);
      chk("wd_err_early", 64'(busy_err_o), 0);
      tick();
    end
    #1 chk("wd_stall_last", 64'(stall_o), 1);
    tick();
    chk("wd_err", 64'(busy_err_o), 1);
    chk("wd_annul", 64'(div_annul_o), 1);
    chk("wd_start_off", 64'(div_start_o), 0);
    chk("wd_stall_rel", 64'(stall_o), 0);
    alu_control_i = NOP;
    tick();
    chk("wd_err_pulse", 64'(busy_err_o), 0);
    chk("wd_we", 64'(hilo_we_o), 0);

    // 6b. Reset mid-BUSY
    alu_control_i = DIV; opdata1_i = 32'd9; opdata2_i = 32'd2;
    tick();
    tick();
    rst = 1'b1; alu_control_i = NOP;
    tick();
    rst = 1'b0;
    #1 chk("mrst_start", 64'(div_start_o), 0);
    chk("mrst_ops", {div_op1_o, div_op2_o}, 64'd0);
    chk("mrst_hilo", {hi_o, lo_o}, 64'd0);
    chk("mrst_flags", 64'({div_signed_o, div_annul_o, busy_err_o, stall_o}), 0);
    tick();
    chk("mrst_we", 64'(hilo_we_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
